sevenseg_scan: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display. It latches a 4-nibble display word from the game logic, for example score / slash / time with nibble 0xF rendering the slash glyph. It cycles the active-low anodes one digit at a time, with a dark blanking gap between digits to suppress ghosting. Segment decode is done by an internal instance of the team's `sevenseg` decoder. The block sits between the score/timer logic and the board's `an`/`seg`/`dp` pins.

---
 rtl/sevenseg_scan.sv | 165 ++++++++++++++++
 tb/tb_sevenseg_scan.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_scan.sv
// Multiplexed 4-digit common-anode seven-segment scan controller.
// The display word is double-buffered and committed only at frame start.

module sevenseg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_o
);

  logic [6:0] seg_on;

  // Active-high {a,b,c,d,e,f,g}; 0xF renders a slash instead of "F".
  always_comb begin
    seg_on = 7'b0000000;
    case (hex_i)
      4'h0:    seg_on = 7'b1111110;
      4'h1:    seg_on = 7'b0110000;
      4'h2:    seg_on = 7'b1101101;
      4'h3:    seg_on = 7'b1111001;
      4'h4:    seg_on = 7'b0110011;
      4'h5:    seg_on = 7'b1011011;
      4'h6:    seg_on = 7'b1011111;
      4'h7:    seg_on = 7'b1110000;
      4'h8:    seg_on = 7'b1111111;
      4'h9:    seg_on = 7'b1111011;
      4'hA:    seg_on = 7'b1110111;
      4'hB:    seg_on = 7'b0011111;
      4'hC:    seg_on = 7'b1001110;
      4'hD:    seg_on = 7'b0111101;
      4'hE:    seg_on = 7'b1001111;
      default: seg_on = 7'b0100101;
    endcase
  end

  assign seg_n_o = ~seg_on;

endmodule

module sevenseg_scan #(
  parameter int unsigned SHOW_CYCLES  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned CNT_MAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t           state_q, state_d;
  logic [1:0]       digit_q, digit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sh_value_q, sh_value_d, act_value_q, act_value_d;
  logic [3:0]       sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [3:0]       sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic             pending_q, pending_d;
  logic             frame_done_q, frame_done_d;
  logic [6:0]       dec_seg_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      digit_q      <= 2'd0;
      cnt_q        <= '0;
      sh_value_q   <= 16'h0000;
      sh_blank_q   <= 4'hF;
      sh_dp_q      <= 4'h0;
      act_value_q  <= 16'h0000;
      act_blank_q  <= 4'hF;
      act_dp_q     <= 4'h0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_q      <= digit_d;
      cnt_q        <= cnt_d;
      sh_value_q   <= sh_value_d;
      sh_blank_q   <= sh_blank_d;
      sh_dp_q      <= sh_dp_d;
      act_value_q  <= act_value_d;
      act_blank_q  <= act_blank_d;
      act_dp_q     <= act_dp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    digit_d      = digit_q;
    cnt_d        = cnt_q + CNT_W'(1);
    sh_value_d   = sh_value_q;
    sh_blank_d   = sh_blank_q;
    sh_dp_d      = sh_dp_q;
    act_value_d  = act_value_q;
    act_blank_d  = act_blank_q;
    act_dp_d     = act_dp_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          // Commit only at the start of digit 0 so a frame never mixes words.
          if (digit_q == 2'd0 && pending_q) begin
            act_value_d = sh_value_q;
            act_blank_d = sh_blank_q;
            act_dp_d    = sh_dp_q;
            pending_d   = 1'b0;
          end
        end
      end
      default: begin
        if (cnt_q == SHOW_LAST) begin
          state_d      = ST_BLANK;
          cnt_d        = '0;
          digit_d      = digit_q + 2'd1;
          frame_done_d = (digit_q == 2'd3);
        end
      end
    endcase

    // A load on the commit edge lands in the shadow and stays pending.
    if (load) begin
      sh_value_d = value;
      sh_blank_d = blank;
      sh_dp_d    = dp;
      pending_d  = 1'b1;
    end
  end

  sevenseg u_dec (
    .hex_i   (act_value_q[{digit_q, 2'b00} +: 4]),
    .seg_n_o (dec_seg_n)
  );

  always_comb begin
    an   = 4'hF;
    seg  = 7'h7F;
    dp_n = 1'b1;
    if (state_q == ST_SHOW && !act_blank_q[digit_q]) begin
      an   = ~(4'b0001 << digit_q);
      seg  = dec_seg_n;
      dp_n = ~act_dp_q[digit_q];
    end
  end

  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: a frame-position model predicts every
// cycle's outputs; a negedge monitor pops and compares them.

module tb_sevenseg_scan;

  localparam int SHOW  = 4;
  localparam int BLNK  = 2;
  localparam int SLOT  = SHOW + BLNK;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame_done;
  logic        pending;

  sevenseg_scan #(.SHOW_CYCLES(SHOW), .BLANK_CYCLES(BLNK)) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .blank      (blank),
    .dp         (dp),
    .load       (load),
    .an         (an),
    .seg        (seg),
    .dp_n       (dp_n),
    .frame_done (frame_done),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       fd;
    logic       pend;
    int         t;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, as seen at the start of cycle m_t.
  bit          m_valid = 0;
  int          m_t;
  logic [15:0] m_sv, m_av;
  logic [3:0]  m_sb, m_ab, m_sd, m_ad;
  bit          m_pend;

  function automatic logic [6:0] seg_on(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b0100101;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1;
    m_t = 0;
    m_sv = 16'h0; m_av = 16'h0;
    m_sb = 4'hF;  m_ab = 4'hF;
    m_sd = 4'h0;  m_ad = 4'h0;
    m_pend = 0;
  endtask

  task automatic push_expect();
    exp_t e;
    int p, d;
    logic [3:0] one;
    one = 4'b0001;
    p = m_t % FRAME;
    d = p / SLOT;
    e.an = 4'hF; e.seg = 7'h7F; e.dp_n = 1'b1;
    if ((p % SLOT) >= BLNK && !m_ab[d]) begin
      e.an   = ~(one << d);
      e.seg  = ~seg_on(m_av[d*4 +: 4]);
      e.dp_n = ~m_ad[d];
    end
    e.fd   = (m_t >= FRAME) && (p == 0);
    e.pend = m_pend;
    e.t    = m_t;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, record the prediction, then advance the model.
  task automatic step(input bit r, input bit ld, input logic [15:0] v,
                      input logic [3:0] b, input logic [3:0] d);
    rst = r; load = ld; value = v; blank = b; dp = d;
    if (m_valid) push_expect();
    @(posedge clk);
    if (r) model_reset();
    else if (m_valid) begin
      if ((m_t % FRAME) == BLNK - 1 && m_pend) begin
        m_av = m_sv; m_ab = m_sb; m_ad = m_sd; m_pend = 0;
      end
      if (ld) begin
        m_sv = v; m_sb = b; m_sd = d; m_pend = 1;
      end
      m_t++;
    end
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
  endtask

  // Run n cycles with optional load A at la, load B at lb and a reset pulse at rc.
  task automatic sched(input int n, input int la, input int lb, input int rc,
                       input logic [15:0] va, input logic [3:0] ba, input logic [3:0] da,
                       input logic [15:0] vb, input logic [3:0] bb, input logic [3:0] db);
    for (int c = 0; c < n; c++) begin
      if (c == rc)      step(1'b1, 1'b1, vb, bb, db);
      else if (c == la) step(1'b0, 1'b1, va, ba, da);
      else if (c == lb) step(1'b0, 1'b1, vb, bb, db);
      else              step(1'b0, 1'b0, 16'hDEAD, 4'h5, 4'hA);
    end
  endtask

  task automatic chk(input string name, input int t, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0d got=%h want=%h", name, t, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an",         e.t, {3'b0, an},         {3'b0, e.an});
        chk("seg",        e.t, seg,                e.seg);
        chk("dp_n",       e.t, {6'b0, dp_n},       {6'b0, e.dp_n});
        chk("frame_done", e.t, {6'b0, frame_done}, {6'b0, e.fd});
        chk("pending",    e.t, {6'b0, pending},    {6'b0, e.pend});
      end
    end
  end

  initial begin : stimulus
    logic [15:0] v;
    logic [3:0]  b, d;
    bit r, ld;

    $display("scenario 1: reset release, no load");
    do_reset();
    sched(30, -1, -1, -1, 16'h0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0);

    $display("scenario 2: load 12F5 at cycle 0");
    do_reset();
    sched(50, 0, -1, -1, 16'h12F5, 4'h0, 4'b0100, 16'h0, 4'h0, 4'h0);

    $display("scenario 3: mid-frame load at cycle 10");
    do_reset();
    sched(60, 0, 10, -1, 16'h4321, 4'h0, 4'b0001, 16'h0000, 4'h0, 4'h0);

    $display("scenario 4: double load at cycles 10 and 15");
    do_reset();
    sched(10, 0, -1, -1, 16'h9876, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0);
    sched(50, 0, 5, -1, 16'hABCD, 4'h0, 4'b1000, 16'h5A3E, 4'b0010, 4'b0110);

    $display("scenario 5: digit 3 blanked, value 8888");
    do_reset();
    sched(50, 0, -1, -1, 16'h8888, 4'b1000, 4'h0, 16'h0, 4'h0, 4'h0);

    $display("scenario 6: reset at cycle 9, reload after");
    do_reset();
    sched(9, 0, -1, -1, 16'h7654, 4'h0, 4'hF, 16'h0, 4'h0, 4'h0);
    sched(3, -1, -1, 0, 16'h0, 4'h0, 4'h0, 16'hFFFF, 4'h0, 4'h0);
    sched(40, 0, -1, -1, 16'h0B1E, 4'b0100, 4'b0011, 16'h0, 4'h0, 4'h0);

    $display("scenario 7: random loads and resets");
    do_reset();
    for (int i = 0; i < 700; i++) begin
      r  = ($urandom_range(0, 249) == 0);
      ld = ($urandom_range(0, 14) == 0);
      v  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      d  = 4'($urandom);
      step(r, ld, v, b, d);
    end

    #20;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 unchecked expectations", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
